// File: rtl/led_latch_bank.sv
// Multi-channel display latch: holds CPU-written words per channel and presents
// one channel on a registered output, chosen by fixed select, rotation or last write.
module led_latch_bank #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 4,
    parameter int CH_W     = $clog2(CHANNELS),
    parameter int DWELL    = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                clr,
    input  logic [1:0]          mode,
    input  logic [CH_W-1:0]     sel_ch,
    output logic [DATA_W-1:0]   data_out,
    output logic [CH_W-1:0]     out_ch,
    output logic [CHANNELS-1:0] valid_mask,
    output logic                upd
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CH_W:0]    CH_LAST  = (CH_W+1)'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_LAST   = 2'b10,
        MODE_ALIAS  = 2'b11
    } mode_e;

    logic [DATA_W-1:0]   r_bank [CHANNELS];
    logic [CHANNELS-1:0] r_valid;
    logic [DATA_W-1:0]   r_data_out;
    logic [CH_W-1:0]     r_out_ch;
    logic                r_upd;
    logic [CNT_W-1:0]    r_cnt;
    logic [CH_W-1:0]     r_last;
    logic                r_rot_prev;

    logic                w_rot;
    logic                w_wr_ok;
    logic                w_wrap;
    logic                w_found;
    logic [CH_W-1:0]     w_adv_ch;
    logic [CH_W-1:0]     w_next_ch;
    logic [DATA_W-1:0]   w_next_data;

    assign w_rot   = (mode == MODE_ROTATE);
    assign w_wr_ok = wr_en && ({1'b0, wr_ch} <= CH_LAST);
    assign w_wrap  = (r_cnt == CNT_LAST);

    // Next valid channel strictly above the current one, wrapping; may land on itself.
    always_comb begin
        logic [CH_W-1:0] v_idx;
        w_found  = 1'b0;
        w_adv_ch = r_out_ch;
        v_idx    = r_out_ch;
        for (int i = 0; i < CHANNELS; i++) begin
            v_idx = ({1'b0, v_idx} >= CH_LAST) ? '0 : v_idx + 1'b1;
            if (!w_found && r_valid[v_idx]) begin
                w_found  = 1'b1;
                w_adv_ch = v_idx;
            end
        end
    end

    always_comb begin
        w_next_ch = sel_ch;
        if (w_rot) begin
            w_next_ch = r_out_ch;
            if (r_rot_prev && w_wrap && w_found) begin
                w_next_ch = w_adv_ch;
            end
        end else if (mode == MODE_LAST) begin
            w_next_ch = r_last;
        end
        w_next_data = ({1'b0, w_next_ch} <= CH_LAST) ? r_bank[w_next_ch] : '0;
    end

    // Bank, valid mask and last-written index; a write on a clear edge lands on top.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_bank[i] <= '0;
            end
            r_valid <= '0;
            r_last  <= '0;
        end else begin
            if (clr) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    r_bank[i] <= '0;
                end
                r_valid <= '0;
            end
            if (w_wr_ok) begin
                r_bank[wr_ch]  <= wr_data;
                r_valid[wr_ch] <= 1'b1;
                r_last         <= wr_ch;
            end
        end
    end

    // Reset counts as a rotation restart, so r_rot_prev follows mode through it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rot_prev <= w_rot;
        end else begin
            r_rot_prev <= w_rot;
            if (w_rot && r_rot_prev && !w_wrap) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_out_ch   <= '0;
            r_upd      <= 1'b0;
        end else begin
            r_data_out <= w_next_data;
            r_out_ch   <= w_next_ch;
            r_upd      <= (w_next_data != r_data_out);
        end
    end

    assign data_out   = r_data_out;
    assign out_ch     = r_out_ch;
    assign valid_mask = r_valid;
    assign upd        = r_upd;

endmodule

// File: tb/tb_led_latch_bank.sv
// Directed bench for led_latch_bank: a 4-channel/DWELL=3 instance and a
// 3-channel/DWELL=2 instance share one stimulus stream.
module tb_led_latch_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [31:0] wr_data;
    logic        clr;
    logic [1:0]  mode;
    logic [1:0]  sel_ch;

    logic [31:0] d4_data;
    logic [1:0]  d4_ch;
    logic [3:0]  d4_valid;
    logic        d4_upd;
    logic [31:0] d3_data;
    logic [1:0]  d3_ch;
    logic [2:0]  d3_valid;
    logic        d3_upd;

    int n_checks = 0;
    int n_errs   = 0;

    logic [31:0] exp_ch_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_upd_q[$];

    always #5 clk = ~clk;

    led_latch_bank #(.DATA_W(32), .CHANNELS(4), .DWELL(3)) u_dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .clr(clr), .mode(mode), .sel_ch(sel_ch),
        .data_out(d4_data), .out_ch(d4_ch), .valid_mask(d4_valid), .upd(d4_upd)
    );

    led_latch_bank #(.DATA_W(32), .CHANNELS(3), .DWELL(2)) u_dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .clr(clr), .mode(mode), .sel_ch(sel_ch),
        .data_out(d3_data), .out_ch(d3_ch), .valid_mask(d3_valid), .upd(d3_upd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] ch, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        clr = 1'b0; mode = 2'b00; sel_ch = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_data", d4_data, 32'h0);
        check("rst_ch", {30'b0, d4_ch}, 32'h0);
        check("rst_valid", {28'b0, d4_valid}, 32'h0);
        check("rst_upd", {31'b0, d4_upd}, 32'h0);

        // Write-to-display latency on fixed channel 2
        sel_ch = 2'd2;
        write(2'd2, 32'hDEAD_BEEF);
        check("wr_k_data", d4_data, 32'h0);
        check("wr_k_valid", {28'b0, d4_valid}, 32'h4);
        check("wr_k_ch", {30'b0, d4_ch}, 32'h2);
        tick();
        check("wr_k1_data", d4_data, 32'hDEAD_BEEF);
        check("wr_k1_upd", {31'b0, d4_upd}, 32'h1);
        tick();
        check("wr_k2_upd", {31'b0, d4_upd}, 32'h0);

        // Rotation skips unwritten channels 1 and 3
        sel_ch = 2'd0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_valid", {28'b0, d4_valid}, 32'h0);
        write(2'd0, 32'h11);
        write(2'd2, 32'h22);
        mode = 2'b01;
        exp_ch_q   = '{0, 0, 0, 2, 2, 2, 0, 0, 0};
        exp_data_q = '{32'h11, 32'h11, 32'h11, 32'h22, 32'h22, 32'h22, 32'h11, 32'h11, 32'h11};
        exp_upd_q  = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
        while (exp_ch_q.size() > 0) begin
            tick();
            check("rot_ch", {30'b0, d4_ch}, exp_ch_q.pop_front());
            check("rot_data", d4_data, exp_data_q.pop_front());
            check("rot_upd", {31'b0, d4_upd}, exp_upd_q.pop_front());
        end

        // Last-written tracking, then clear keeps the index
        mode = 2'b10;
        write(2'd3, 32'hA5);
        tick();
        check("last_ch3", {30'b0, d4_ch}, 32'h3);
        check("last_d3", d4_data, 32'hA5);
        write(2'd1, 32'h5A);
        tick();
        check("last_ch1", {30'b0, d4_ch}, 32'h1);
        check("last_d1", d4_data, 32'h5A);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("lclr_valid", {28'b0, d4_valid}, 32'h0);
        tick();
        check("lclr_data", d4_data, 32'h0);
        check("lclr_ch", {30'b0, d4_ch}, 32'h1);

        // Clear plus write on the same edge
        mode = 2'b00;
        write(2'd0, 32'h1);
        write(2'd1, 32'h2);
        write(2'd2, 32'h3);
        write(2'd3, 32'h4);
        check("full_valid", {28'b0, d4_valid}, 32'hF);
        clr = 1'b1;
        write(2'd1, 32'h77);
        clr = 1'b0;
        check("cw_valid", {28'b0, d4_valid}, 32'h2);
        for (int i = 0; i < 4; i++) begin
            sel_ch = 2'(i);
            tick();
            check("cw_ch", {30'b0, d4_ch}, 32'(i));
            check("cw_data", d4_data, (i == 1) ? 32'h77 : 32'h0);
        end

        // Out-of-range channel on the 3-channel instance
        check("c3_valid", {29'b0, d3_valid}, 32'h2);
        sel_ch = 2'd1;
        write(2'd3, 32'hBAD);
        check("c3_oor_wr", {29'b0, d3_valid}, 32'h2);
        tick();
        check("c3_d1", d3_data, 32'h77);
        sel_ch = 2'd3;
        tick();
        check("c3_oor_data", d3_data, 32'h0);
        check("c3_oor_ch", {30'b0, d3_ch}, 32'h3);
        check("c3_oor_upd", {31'b0, d3_upd}, 32'h1);

        // Reset mid-dwell in rotate mode
        mode = 2'b01;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rrst_data", d4_data, 32'h0);
        check("rrst_ch", {30'b0, d4_ch}, 32'h0);
        check("rrst_valid", {28'b0, d4_valid}, 32'h0);
        check("rrst_upd", {31'b0, d4_upd}, 32'h0);
        write(2'd1, 32'h33);
        check("rrst_r1_ch", {30'b0, d4_ch}, 32'h0);
        tick();
        check("rrst_r2_ch", {30'b0, d4_ch}, 32'h0);
        tick();
        check("rrst_r3_ch", {30'b0, d4_ch}, 32'h1);
        check("rrst_r3_data", d4_data, 32'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule
